// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared types and constants for the AXI4-Lite crossbar
package axi_lite_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        SEL_S0   = 2'd0,
        SEL_S1   = 2'd1,
        SEL_NONE = 2'd2
    } sel_e;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_FWD  = 2'd1,
        WR_RESP = 2'd2,
        WR_ERR  = 2'd3
    } wr_state_e;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_FWD  = 2'd1,
        RD_RESP = 2'd2,
        RD_ERR  = 2'd3
    } rd_state_e;

endpackage

// File: rtl/axi_lite_addr_decode.sv
// rtl/axi_lite_addr_decode.sv - maps an address onto one of the two slave windows
module axi_lite_addr_decode
    import axi_lite_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] S0_BASE    = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] S1_BASE    = 32'h0000_1000,
    parameter int                    WIN_BITS   = 12
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output sel_e                  sel
);

    always_comb begin
        sel = SEL_NONE;
        if ((addr >> WIN_BITS) == (S0_BASE >> WIN_BITS)) begin
            sel = SEL_S0;
        end else if ((addr >> WIN_BITS) == (S1_BASE >> WIN_BITS)) begin
            sel = SEL_S1;
        end
    end

endmodule

// File: rtl/axi_lite_interconnect.sv
// rtl/axi_lite_interconnect.sv - 1-master to 2-slave AXI4-Lite crossbar with DECERR responder
module axi_lite_interconnect
    import axi_lite_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] S0_BASE    = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] S1_BASE    = 32'h0000_1000,
    parameter int                    WIN_BITS   = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   M_awaddr,
    input  logic                    M_awvalid,
    output logic                    M_awready,
    input  logic [DATA_WIDTH-1:0]   M_wdata,
    input  logic [DATA_WIDTH/8-1:0] M_wstrb,
    input  logic                    M_wvalid,
    output logic                    M_wready,
    output logic [1:0]              M_bresp,
    output logic                    M_bvalid,
    input  logic                    M_bready,
    input  logic [ADDR_WIDTH-1:0]   M_araddr,
    input  logic                    M_arvalid,
    output logic                    M_arready,
    output logic [DATA_WIDTH-1:0]   M_rdata,
    output logic [1:0]              M_rresp,
    output logic                    M_rvalid,
    input  logic                    M_rready,
    output logic [ADDR_WIDTH-1:0]   S0_awaddr,
    output logic                    S0_awvalid,
    input  logic                    S0_awready,
    output logic [DATA_WIDTH-1:0]   S0_wdata,
    output logic [DATA_WIDTH/8-1:0] S0_wstrb,
    output logic                    S0_wvalid,
    input  logic                    S0_wready,
    input  logic [1:0]              S0_bresp,
    input  logic                    S0_bvalid,
    output logic                    S0_bready,
    output logic [ADDR_WIDTH-1:0]   S0_araddr,
    output logic                    S0_arvalid,
    input  logic                    S0_arready,
    input  logic [DATA_WIDTH-1:0]   S0_rdata,
    input  logic [1:0]              S0_rresp,
    input  logic                    S0_rvalid,
    output logic                    S0_rready,
    output logic [ADDR_WIDTH-1:0]   S1_awaddr,
    output logic                    S1_awvalid,
    input  logic                    S1_awready,
    output logic [DATA_WIDTH-1:0]   S1_wdata,
    output logic [DATA_WIDTH/8-1:0] S1_wstrb,
    output logic                    S1_wvalid,
    input  logic                    S1_wready,
    input  logic [1:0]              S1_bresp,
    input  logic                    S1_bvalid,
    output logic                    S1_bready,
    output logic [ADDR_WIDTH-1:0]   S1_araddr,
    output logic                    S1_arvalid,
    input  logic                    S1_arready,
    input  logic [DATA_WIDTH-1:0]   S1_rdata,
    input  logic [1:0]              S1_rresp,
    input  logic                    S1_rvalid,
    output logic                    S1_rready
);

    sel_e      aw_sel, ar_sel;
    wr_state_e wr_state_q, wr_state_d;
    rd_state_e rd_state_q, rd_state_d;
    sel_e      wsel_q, wsel_d, rsel_q, rsel_d;
    logic      aw_done_q, aw_done_d, w_done_q, w_done_d, ar_done_q, ar_done_d;
    logic      widx, ridx;

    logic [1:0]            s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [1:0]            s_arvalid, s_arready, s_rvalid, s_rready;
    logic [1:0]            s_bresp [2];
    logic [1:0]            s_rresp [2];
    logic [DATA_WIDTH-1:0] s_rdata [2];

    axi_lite_addr_decode #(
        .ADDR_WIDTH(ADDR_WIDTH), .S0_BASE(S0_BASE), .S1_BASE(S1_BASE), .WIN_BITS(WIN_BITS)
    ) u_aw_decode (.addr(M_awaddr), .sel(aw_sel));

    axi_lite_addr_decode #(
        .ADDR_WIDTH(ADDR_WIDTH), .S0_BASE(S0_BASE), .S1_BASE(S1_BASE), .WIN_BITS(WIN_BITS)
    ) u_ar_decode (.addr(M_araddr), .sel(ar_sel));

    // Payload buses fan out to both slaves; only the handshakes are steered.
    assign S0_awaddr = M_awaddr;
    assign S1_awaddr = M_awaddr;
    assign S0_wdata  = M_wdata;
    assign S1_wdata  = M_wdata;
    assign S0_wstrb  = M_wstrb;
    assign S1_wstrb  = M_wstrb;
    assign S0_araddr = M_araddr;
    assign S1_araddr = M_araddr;

    assign s_awready  = {S1_awready, S0_awready};
    assign s_wready   = {S1_wready, S0_wready};
    assign s_bvalid   = {S1_bvalid, S0_bvalid};
    assign s_arready  = {S1_arready, S0_arready};
    assign s_rvalid   = {S1_rvalid, S0_rvalid};
    assign s_bresp[0] = S0_bresp;
    assign s_bresp[1] = S1_bresp;
    assign s_rresp[0] = S0_rresp;
    assign s_rresp[1] = S1_rresp;
    assign s_rdata[0] = S0_rdata;
    assign s_rdata[1] = S1_rdata;

    assign {S1_awvalid, S0_awvalid} = s_awvalid;
    assign {S1_wvalid, S0_wvalid}   = s_wvalid;
    assign {S1_bready, S0_bready}   = s_bready;
    assign {S1_arvalid, S0_arvalid} = s_arvalid;
    assign {S1_rready, S0_rready}   = s_rready;

    assign widx = (wsel_q == SEL_S1);
    assign ridx = (rsel_q == SEL_S1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_state_q <= WR_IDLE;
            rd_state_q <= RD_IDLE;
            wsel_q     <= SEL_NONE;
            rsel_q     <= SEL_NONE;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            ar_done_q  <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            wsel_q     <= wsel_d;
            rsel_q     <= rsel_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            ar_done_q  <= ar_done_d;
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        wsel_d     = wsel_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        M_awready  = 1'b0;
        M_wready   = 1'b0;
        M_bvalid   = 1'b0;
        M_bresp    = RESP_OKAY;
        s_awvalid  = 2'b00;
        s_wvalid   = 2'b00;
        s_bready   = 2'b00;
        case (wr_state_q)
            WR_IDLE: begin
                if (M_awvalid) begin
                    wsel_d     = aw_sel;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    wr_state_d = (aw_sel == SEL_NONE) ? WR_ERR : WR_FWD;
                end
            end
            WR_FWD: begin
                s_awvalid[widx] = M_awvalid & ~aw_done_q;
                s_wvalid[widx]  = M_wvalid & ~w_done_q;
                M_awready       = s_awready[widx] & ~aw_done_q;
                M_wready        = s_wready[widx] & ~w_done_q;
                aw_done_d       = aw_done_q | (M_awvalid & M_awready);
                w_done_d        = w_done_q | (M_wvalid & M_wready);
                if (aw_done_d && w_done_d) begin
                    wr_state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                M_bvalid        = s_bvalid[widx];
                M_bresp         = M_bvalid ? s_bresp[widx] : RESP_OKAY;
                s_bready[widx]  = M_bready;
                if (M_bvalid && M_bready) begin
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    wsel_d     = SEL_NONE;
                    wr_state_d = WR_IDLE;
                end
            end
            WR_ERR: begin
                // Soak up both channels locally, then answer DECERR.
                M_awready = ~aw_done_q;
                M_wready  = ~w_done_q;
                aw_done_d = aw_done_q | M_awvalid;
                w_done_d  = w_done_q | M_wvalid;
                M_bvalid  = aw_done_q & w_done_q;
                M_bresp   = M_bvalid ? RESP_DECERR : RESP_OKAY;
                if (M_bvalid && M_bready) begin
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    wsel_d     = SEL_NONE;
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rsel_d     = rsel_q;
        ar_done_d  = ar_done_q;
        M_arready  = 1'b0;
        M_rvalid   = 1'b0;
        M_rresp    = RESP_OKAY;
        M_rdata    = '0;
        s_arvalid  = 2'b00;
        s_rready   = 2'b00;
        case (rd_state_q)
            RD_IDLE: begin
                if (M_arvalid) begin
                    rsel_d     = ar_sel;
                    ar_done_d  = 1'b0;
                    rd_state_d = (ar_sel == SEL_NONE) ? RD_ERR : RD_FWD;
                end
            end
            RD_FWD: begin
                s_arvalid[ridx] = M_arvalid;
                M_arready       = s_arready[ridx];
                if (M_arvalid && M_arready) begin
                    rd_state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                M_rvalid        = s_rvalid[ridx];
                M_rresp         = M_rvalid ? s_rresp[ridx] : RESP_OKAY;
                M_rdata         = M_rvalid ? s_rdata[ridx] : '0;
                s_rready[ridx]  = M_rready;
                if (M_rvalid && M_rready) begin
                    rsel_d     = SEL_NONE;
                    rd_state_d = RD_IDLE;
                end
            end
            RD_ERR: begin
                M_arready = ~ar_done_q;
                ar_done_d = ar_done_q | M_arvalid;
                M_rvalid  = ar_done_q;
                M_rresp   = M_rvalid ? RESP_DECERR : RESP_OKAY;
                if (M_rvalid && M_rready) begin
                    ar_done_d  = 1'b0;
                    rsel_d     = SEL_NONE;
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_lite_interconnect.sv
// tb/tb_axi_lite_interconnect.sv - directed self-checking bench with two memory slave models
module tb_axi_lite_interconnect;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] M_awaddr, M_wdata, M_araddr, M_rdata;
    logic [3:0]  M_wstrb;
    logic        M_awvalid, M_awready, M_wvalid, M_wready, M_bvalid, M_bready;
    logic        M_arvalid, M_arready, M_rvalid, M_rready;
    logic [1:0]  M_bresp, M_rresp;

    logic [1:0]  s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [1:0]  s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0] s_awaddr [2];
    logic [31:0] s_wdata [2];
    logic [31:0] s_araddr [2];
    logic [31:0] s_rdata [2];
    logic [3:0]  s_wstrb [2];
    logic [1:0]  s_bresp [2];
    logic [1:0]  s_rresp [2];

    logic [1:0]  aw_have, w_have;
    logic [31:0] aw_l [2];
    logic [31:0] w_l [2];
    logic [3:0]  st_l [2];
    logic [31:0] mem [2][16];
    int          wr_cnt [2] = '{0, 0};
    int          vcyc [2] = '{0, 0};

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    axi_lite_interconnect dut (
        .clk(clk), .reset(reset),
        .M_awaddr(M_awaddr), .M_awvalid(M_awvalid), .M_awready(M_awready),
        .M_wdata(M_wdata), .M_wstrb(M_wstrb), .M_wvalid(M_wvalid), .M_wready(M_wready),
        .M_bresp(M_bresp), .M_bvalid(M_bvalid), .M_bready(M_bready),
        .M_araddr(M_araddr), .M_arvalid(M_arvalid), .M_arready(M_arready),
        .M_rdata(M_rdata), .M_rresp(M_rresp), .M_rvalid(M_rvalid), .M_rready(M_rready),
        .S0_awaddr(s_awaddr[0]), .S0_awvalid(s_awvalid[0]), .S0_awready(s_awready[0]),
        .S0_wdata(s_wdata[0]), .S0_wstrb(s_wstrb[0]), .S0_wvalid(s_wvalid[0]), .S0_wready(s_wready[0]),
        .S0_bresp(s_bresp[0]), .S0_bvalid(s_bvalid[0]), .S0_bready(s_bready[0]),
        .S0_araddr(s_araddr[0]), .S0_arvalid(s_arvalid[0]), .S0_arready(s_arready[0]),
        .S0_rdata(s_rdata[0]), .S0_rresp(s_rresp[0]), .S0_rvalid(s_rvalid[0]), .S0_rready(s_rready[0]),
        .S1_awaddr(s_awaddr[1]), .S1_awvalid(s_awvalid[1]), .S1_awready(s_awready[1]),
        .S1_wdata(s_wdata[1]), .S1_wstrb(s_wstrb[1]), .S1_wvalid(s_wvalid[1]), .S1_wready(s_wready[1]),
        .S1_bresp(s_bresp[1]), .S1_bvalid(s_bvalid[1]), .S1_bready(s_bready[1]),
        .S1_araddr(s_araddr[1]), .S1_arvalid(s_arvalid[1]), .S1_arready(s_arready[1]),
        .S1_rdata(s_rdata[1]), .S1_rresp(s_rresp[1]), .S1_rvalid(s_rvalid[1]), .S1_rready(s_rready[1])
    );

    // Slave models: 16-word memories; word 15 answers SLVERR.
    assign s_awready = ~aw_have;
    assign s_wready  = ~w_have;
    assign s_arready = ~s_rvalid;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                aw_have[k]  <= 1'b0;
                w_have[k]   <= 1'b0;
                s_bvalid[k] <= 1'b0;
                s_rvalid[k] <= 1'b0;
                s_bresp[k]  <= 2'b00;
                s_rresp[k]  <= 2'b00;
                s_rdata[k]  <= 32'h0;
            end else begin
                if (s_awvalid[k] || s_wvalid[k] || s_arvalid[k]) vcyc[k] <= vcyc[k] + 1;
                if (s_awvalid[k] && s_awready[k]) begin
                    aw_have[k] <= 1'b1;
                    aw_l[k]    <= s_awaddr[k];
                end
                if (s_wvalid[k] && s_wready[k]) begin
                    w_have[k] <= 1'b1;
                    w_l[k]    <= s_wdata[k];
                    st_l[k]   <= s_wstrb[k];
                end
                if (aw_have[k] && w_have[k] && !s_bvalid[k]) begin
                    for (int b = 0; b < 4; b++)
                        if (st_l[k][b]) mem[k][aw_l[k][5:2]][8*b +: 8] <= w_l[k][8*b +: 8];
                    s_bvalid[k] <= 1'b1;
                    s_bresp[k]  <= (aw_l[k][5:2] == 4'hF) ? 2'b10 : 2'b00;
                    aw_have[k]  <= 1'b0;
                    w_have[k]   <= 1'b0;
                    wr_cnt[k]   <= wr_cnt[k] + 1;
                end
                if (s_bvalid[k] && s_bready[k]) s_bvalid[k] <= 1'b0;
                if (s_arvalid[k] && s_arready[k]) begin
                    s_rvalid[k] <= 1'b1;
                    s_rdata[k]  <= mem[k][s_araddr[k][5:2]];
                    s_rresp[k]  <= (s_araddr[k][5:2] == 4'hF) ? 2'b10 : 2'b00;
                end
                if (s_rvalid[k] && s_rready[k]) s_rvalid[k] <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int lead, input int bdly, output logic [1:0] resp);
        logic a, w;
        int   n;
        @(negedge clk);
        M_awaddr = addr;
        M_wdata  = data;
        M_wstrb  = strb;
        if (lead > 0) begin
            M_wvalid = 1'b1;
            for (int i = 0; i < lead; i++) begin
                #1 chk("w_early_wready", M_wready, 0);
                @(negedge clk);
            end
        end
        M_awvalid = 1'b1;
        M_wvalid  = 1'b1;
        n = 0;
        while ((M_awvalid || M_wvalid) && n < 40) begin
            #1;
            a = M_awvalid && M_awready;
            w = M_wvalid && M_wready;
            @(negedge clk);
            if (a) M_awvalid = 1'b0;
            if (w) M_wvalid = 1'b0;
            n++;
        end
        chk("aw_w_accepted", {M_awvalid, M_wvalid}, 0);
        M_awvalid = 1'b0;
        M_wvalid  = 1'b0;
        n = 0;
        #1;
        while (!M_bvalid && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("bvalid_seen", M_bvalid, 1);
        resp = M_bresp;
        for (int i = 0; i < bdly; i++) begin
            @(negedge clk);
            #1 chk("bvalid_held", M_bvalid, 1);
            chk("bresp_stable", M_bresp, resp);
        end
        M_bready = 1'b1;
        @(negedge clk);
        M_bready = 1'b0;
        #1 chk("bvalid_cleared", {M_bvalid, M_bresp}, 0);
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        @(negedge clk);
        M_araddr  = addr;
        M_arvalid = 1'b1;
        n = 0;
        #1;
        while (!M_arready && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("arready_seen", M_arready, 1);
        @(negedge clk);
        M_arvalid = 1'b0;
        n = 0;
        #1;
        while (!M_rvalid && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("rvalid_seen", M_rvalid, 1);
        data = M_rdata;
        resp = M_rresp;
        M_rready = 1'b1;
        @(negedge clk);
        M_rready = 1'b0;
        #1 chk("rvalid_cleared", {M_rvalid, M_rresp, M_rdata[29:0]}, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  resp, rresp;
        logic [31:0] rd;
        int          c0, c1, v0, v1;

        reset = 1'b0;
        {M_awvalid, M_wvalid, M_bready, M_arvalid, M_rready} = '0;
        M_awaddr = '0; M_wdata = '0; M_wstrb = '0; M_araddr = '0;
        repeat (3) @(negedge clk);
        #1 chk("reset_m_outs", {M_awready, M_wready, M_bvalid, M_arready, M_rvalid, M_bresp, M_rresp}, 0);
        chk("reset_rdata", M_rdata, 0);
        chk("reset_s_outs", {s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready}, 0);
        reset = 1'b1;

        c0 = wr_cnt[0]; v1 = vcyc[1];
        do_write(32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 0, 0, resp);
        chk("s0_wr_bresp", resp, 2'b00);
        chk("s0_wr_count", wr_cnt[0] - c0, 1);
        chk("s0_wr_s1_quiet", vcyc[1] - v1, 0);
        do_read(32'h0000_0004, rd, rresp);
        chk("s0_rd_data", rd, 32'hDEAD_BEEF);
        chk("s0_rd_resp", rresp, 2'b00);

        do_write(32'h0000_0004, 32'h0000_1111, 4'h3, 0, 0, resp);
        do_read(32'h0000_0004, rd, rresp);
        chk("s0_strb_data", rd, 32'hDEAD_1111);

        do_write(32'h0000_0008, 32'hCAFE_F00D, 4'hF, 0, 0, resp);
        c0 = wr_cnt[0]; c1 = wr_cnt[1];
        do_write(32'h0000_1008, 32'h1234_5678, 4'hF, 0, 0, resp);
        chk("s1_wr_count", wr_cnt[1] - c1, 1);
        chk("s1_wr_s0_untouched", wr_cnt[0] - c0, 0);
        do_read(32'h0000_1008, rd, rresp);
        chk("s1_rd_data", rd, 32'h1234_5678);
        do_read(32'h0000_0008, rd, rresp);
        chk("s0_prior_data", rd, 32'hCAFE_F00D);

        v0 = vcyc[0]; v1 = vcyc[1];
        do_write(32'h0000_3000, 32'h5555_AAAA, 4'hF, 0, 0, resp);
        chk("decerr_bresp", resp, 2'b11);
        do_read(32'h0000_3000, rd, rresp);
        chk("decerr_rresp", rresp, 2'b11);
        chk("decerr_rdata", rd, 0);
        chk("decerr_no_slave_valid", (vcyc[0] - v0) + (vcyc[1] - v1), 0);

        do_write(32'h0000_103C, 32'hAAAA_5555, 4'hF, 0, 0, resp);
        chk("slverr_bresp", resp, 2'b10);
        do_read(32'h0000_103C, rd, rresp);
        chk("slverr_rresp", rresp, 2'b10);
        chk("slverr_rdata", rd, 32'hAAAA_5555);

        c1 = wr_cnt[1];
        do_write(32'h0000_1010, 32'hA5A5_0001, 4'hF, 3, 0, resp);
        chk("w_first_count", wr_cnt[1] - c1, 1);
        chk("w_first_bresp", resp, 2'b00);
        c0 = wr_cnt[0];
        do_write(32'h0000_000C, 32'h0000_C0DE, 4'hF, 0, 0, resp);
        chk("same_cycle_count", wr_cnt[0] - c0, 1);
        do_read(32'h0000_1010, rd, rresp);
        chk("w_first_data", rd, 32'hA5A5_0001);

        c1 = wr_cnt[1];
        fork
            do_write(32'h0000_1014, 32'h7777_8888, 4'hF, 0, 5, resp);
            do_read(32'h0000_0004, rd, rresp);
        join
        chk("conc_bresp", resp, 2'b00);
        chk("conc_rd_data", rd, 32'hDEAD_1111);
        chk("conc_wr_count", wr_cnt[1] - c1, 1);
        do_read(32'h0000_1014, rd, rresp);
        chk("conc_wr_data", rd, 32'h7777_8888);

        @(negedge clk);
        M_awaddr = 32'h0000_0000; M_wdata = 32'h0BAD_0BAD; M_wstrb = 4'hF;
        M_awvalid = 1'b1;
        @(negedge clk);
        #1 chk("fwd_s0_awvalid", s_awvalid, 2'b01);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1 chk("midrst_m_outs", {M_awready, M_wready, M_bvalid, M_arready, M_rvalid, M_bresp, M_rresp}, 0);
        chk("midrst_s_outs", {s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready}, 0);
        M_awvalid = 1'b0;
        reset = 1'b1;
        c0 = wr_cnt[0];
        do_write(32'h0000_0000, 32'h600D_F00D, 4'hF, 0, 0, resp);
        chk("post_rst_bresp", resp, 2'b00);
        chk("post_rst_count", wr_cnt[0] - c0, 1);
        do_read(32'h0000_0000, rd, rresp);
        chk("post_rst_data", rd, 32'h600D_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
